cd_csr_host: RTL and testbench
==============================

CD_CSR_HOST -- requirements
Module: cd_csr_host

Interface
REQ-001 Parameter ADDR_INT_FLAG, default 5'h10, is the CSR address of the interrupt flag register.
REQ-002 Parameter ADDR_RX_DATA, default 5'h14, is the CSR address of the RX data read port.
REQ-003 Parameter ADDR_TX_DATA, default 5'h15, is the CSR address of the TX data write port.
REQ-004 Parameter ADDR_RX_CTRL, default 5'h16, is the CSR address of the RX control register.
REQ-005 Parameter ADDR_TX_CTRL, default 5'h17, is the CSR address of the TX control register.
REQ-006 The port list SHALL be:
- clk  in  1  single clock, all logic on rising edge; reset is asynchronous and active-high.
- reset  in  1  asynchronous active-high reset.
- irq  in  1  level interrupt from the cdbus controller.
- csr_address  out  5  CSR address.
- csr_read  out  1  read strobe.
- csr_readdata  in  8  read data, valid the cycle after csr_read.
- csr_write  out  1  write strobe.
- csr_writedata  out  8  write data.
- tx_data  in  8  outbound frame byte.
- tx_valid  in  1  tx_data valid.
- tx_last  in  1  marks final byte of frame.
- tx_ready  out  1  byte accepted when tx_valid&&tx_ready.
- rx_data  out  8  inbound frame byte.
- rx_valid  out  1  rx_data valid.
- rx_last  out  1  marks final byte of frame.
- rx_ready  in  1  consumer accepts when rx_valid&&rx_ready.
- tx_err  out  1  one-cycle pulse, TX frame rejected.
- busy  out  1  FSM not in IDLE.

Function
REQ-007 The FSM SHALL have states IDLE, POLL, POLL_WAIT, TX_WR, TX_SW, RX_RD, RX_WAIT, RX_OUT, RX_DONE.
REQ-008 At most one of csr_read/csr_write SHALL be high per cycle; each is a single-cycle strobe; csr_address/csr_writedata are valid only with the strobe.
REQ-009 IDLE: if irq or tx_valid, go to POLL; POLL issues csr_read of ADDR_INT_FLAG; POLL_WAIT samples csr_readdata.
REQ-010 POLL_WAIT priority: flag bit1 (rx_pending) -> RX_RD; else tx_valid and flag bit5 (tx buffer clean) -> TX_WR; else IDLE.
REQ-011 TX_WR: tx_ready=1 only in this state; each accepted byte SHALL be written to ADDR_TX_DATA in the same cycle; 9-bit byte counter increments.
REQ-012 TX_WR with tx_valid low SHALL wait indefinitely; a TX frame is atomic and RX is not serviced until it completes.
REQ-013 Accepted byte with tx_last -> TX_SW, which writes 8'h02 (switch) to ADDR_TX_CTRL, then IDLE.
REQ-014 Counter reaching 256 accepted bytes without tx_last -> write 8'h04 (abort) to ADDR_TX_CTRL, pulse tx_err, discard remaining bytes up to and including tx_last (tx_ready=1), then IDLE.
REQ-015 RX_RD issues csr_read of ADDR_RX_DATA; RX_WAIT captures csr_readdata into rx_data and enters RX_OUT with rx_valid=1.
REQ-016 RX_OUT SHALL hold rx_data/rx_valid stable until rx_ready; no CSR read issued while rx_valid is high.
REQ-017 Byte index 2 (0-based) SHALL be latched as payload length L; frame total = L+3 bytes; rx_last=1 on byte index L+2.
REQ-018 After the rx_last handshake, RX_DONE writes 8'h02 (read done) to ADDR_RX_CTRL, then IDLE; IDLE re-polls while irq remains high.
REQ-019 Throughput: TX one byte per cycle; RX minimum three cycles per byte.

Reset
REQ-020 On reset: state IDLE; csr_read, csr_write, tx_ready, rx_valid, rx_last, tx_err, busy = 0; csr_address, csr_writedata, rx_data = 0; counters cleared.
REQ-021 Reset asserted mid-frame SHALL abandon the frame immediately; no pending CSR write completes.

Configuration
REQ-022 Macro CD_HOST_LEN_CHECK_EN defined: at tx_last, if accepted count != tx byte index 2 value + 3, TX_SW writes 8'h04 (abort) instead of 8'h02 and pulses tx_err.
REQ-023 CD_HOST_LEN_CHECK_EN undefined: no length comparison; the comparator logic SHALL be absent.

Verification
REQ-024 irq=1, INT_FLAG=8'h02, RX bytes 01 02 02 AA BB, rx_ready=1 -> 5 rx bytes, rx_last on BB, then write 8'h02 to ADDR_RX_CTRL.
REQ-025 INT_FLAG=8'h20, tx frame 01 02 01 55 -> 4 writes to ADDR_TX_DATA back-to-back, then 8'h02 to ADDR_TX_CTRL; tx_err stays 0.
REQ-026 INT_FLAG=8'h00 with tx_valid=1 -> no TX_DATA write, tx_ready=0, FSM returns IDLE and re-polls.
REQ-027 RX with rx_ready held low 10 cycles on byte 3 -> rx_data stable, no csr_read during stall.
REQ-028 With CD_HOST_LEN_CHECK_EN, tx frame 01 02 05 55 -> 8'h04 to ADDR_TX_CTRL, tx_err pulse one cycle.
REQ-029 Reset asserted during TX_WR after 2 bytes -> all outputs at reset values next cycle, no TX_CTRL write.

Source files
------------

// File: rtl/cd_csr_host_if.sv
// cd_csr_host_if: CSR bus, TX/RX byte streams and status between cd_csr_host and its environment.
// master is the host side (drives the CSR bus and RX stream), slave is the controller/consumer side.
interface cd_csr_host_if;
    logic       irq;
    logic [4:0] csr_address;
    logic       csr_read;
    logic [7:0] csr_readdata;
    logic       csr_write;
    logic [7:0] csr_writedata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_last;
    logic       rx_ready;
    logic       tx_err;
    logic       busy;

    modport master (
        input  irq, csr_readdata, tx_data, tx_valid, tx_last, rx_ready,
        output csr_address, csr_read, csr_write, csr_writedata,
               tx_ready, rx_data, rx_valid, rx_last, tx_err, busy
    );

    modport slave (
        output irq, csr_readdata, tx_data, tx_valid, tx_last, rx_ready,
        input  csr_address, csr_read, csr_write, csr_writedata,
               tx_ready, rx_data, rx_valid, rx_last, tx_err, busy
    );
endinterface

// File: rtl/cd_csr_host.sv
// cd_csr_host: moves frames between TX/RX byte streams and a cdbus controller's CSRs.
// Define CD_HOST_LEN_CHECK_EN to abort TX frames whose byte count disagrees with byte 2 (+3).
module cd_csr_host #(
    parameter logic [4:0] ADDR_INT_FLAG = 5'h10,
    parameter logic [4:0] ADDR_RX_DATA  = 5'h14,
    parameter logic [4:0] ADDR_TX_DATA  = 5'h15,
    parameter logic [4:0] ADDR_RX_CTRL  = 5'h16,
    parameter logic [4:0] ADDR_TX_CTRL  = 5'h17
) (
    input  logic          clk,
    input  logic          reset,
    cd_csr_host_if.master bus
);
    localparam logic [7:0] CTRL_DONE   = 8'h02;
    localparam logic [7:0] CTRL_ABORT  = 8'h04;
    localparam logic [8:0] TX_MAX_LAST = 9'd255;

    typedef enum logic [3:0] {
        IDLE, POLL, POLL_WAIT, TX_WR, TX_SW, TX_DROP, RX_RD, RX_WAIT, RX_OUT, RX_DONE
    } state_t;

    state_t     r_state;
    state_t     w_nxt;

    logic [8:0] r_tx_cnt;
    logic       r_tx_abort;
    logic       r_tx_drop;
    logic [8:0] r_rx_idx;
    logic [7:0] r_rx_len;
    logic [7:0] r_rx_data;
    logic       r_rx_last;

    logic [4:0] w_csr_address;
    logic       w_csr_read;
    logic       w_csr_write;
    logic [7:0] w_csr_writedata;
    logic       w_tx_ready;
    logic       w_tx_err;
    logic       w_tx_hs;
    logic       w_tx_ovf;
    logic       w_len_bad;
    logic       w_rx_last;

    assign w_tx_hs = (r_state == TX_WR) && bus.tx_valid;

    // The length byte itself can be the final byte, so index 2 is resolved from the live read data.
    assign w_rx_last = (r_rx_idx == 9'd2) ? (bus.csr_readdata == 8'h00)
                     : ((r_rx_idx > 9'd2) && (r_rx_idx == ({1'b0, r_rx_len} + 9'd2)));

`ifdef CD_HOST_LEN_CHECK_EN
    logic [7:0] r_tx_len;
    logic [7:0] w_len_byte;

    always_comb begin
        w_len_byte = (r_tx_cnt == 9'd2) ? bus.tx_data : r_tx_len;
        w_len_bad  = w_tx_hs && bus.tx_last
                     && (({1'b0, r_tx_cnt} + 10'd1) != ({2'b00, w_len_byte} + 10'd3));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_len <= '0;
        end else if (r_state == POLL_WAIT) begin
            r_tx_len <= '0;
        end else if (w_tx_hs && (r_tx_cnt == 9'd2)) begin
            r_tx_len <= bus.tx_data;
        end
    end
`else
    assign w_len_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt           = r_state;
        w_csr_address   = '0;
        w_csr_read      = 1'b0;
        w_csr_write     = 1'b0;
        w_csr_writedata = '0;
        w_tx_ready      = 1'b0;
        w_tx_err        = 1'b0;
        w_tx_ovf        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.irq || bus.tx_valid) begin
                    w_nxt = POLL;
                end
            end
            POLL: begin
                w_csr_read    = 1'b1;
                w_csr_address = ADDR_INT_FLAG;
                w_nxt         = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (bus.csr_readdata[1]) begin
                    w_nxt = RX_RD;
                end else if (bus.tx_valid && bus.csr_readdata[5]) begin
                    w_nxt = TX_WR;
                end else begin
                    w_nxt = IDLE;
                end
            end
            TX_WR: begin
                w_tx_ready = 1'b1;
                if (bus.tx_valid) begin
                    w_csr_write     = 1'b1;
                    w_csr_address   = ADDR_TX_DATA;
                    w_csr_writedata = bus.tx_data;
                    if (bus.tx_last) begin
                        w_nxt = TX_SW;
                    end else if (r_tx_cnt == TX_MAX_LAST) begin
                        w_tx_ovf = 1'b1;
                        w_nxt    = TX_SW;
                    end
                end
            end
            TX_SW: begin
                w_csr_write     = 1'b1;
                w_csr_address   = ADDR_TX_CTRL;
                w_csr_writedata = r_tx_abort ? CTRL_ABORT : CTRL_DONE;
                w_tx_err        = r_tx_abort;
                w_nxt           = r_tx_drop ? TX_DROP : IDLE;
            end
            TX_DROP: begin
                w_tx_ready = 1'b1;
                if (bus.tx_valid && bus.tx_last) begin
                    w_nxt = IDLE;
                end
            end
            RX_RD: begin
                w_csr_read    = 1'b1;
                w_csr_address = ADDR_RX_DATA;
                w_nxt         = RX_WAIT;
            end
            RX_WAIT: begin
                w_nxt = RX_OUT;
            end
            RX_OUT: begin
                if (bus.rx_ready) begin
                    w_nxt = r_rx_last ? RX_DONE : RX_RD;
                end
            end
            RX_DONE: begin
                w_csr_write     = 1'b1;
                w_csr_address   = ADDR_RX_CTRL;
                w_csr_writedata = CTRL_DONE;
                w_nxt           = IDLE;
            end
            default: begin
                w_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_cnt   <= '0;
            r_tx_abort <= 1'b0;
            r_tx_drop  <= 1'b0;
            r_rx_idx   <= '0;
            r_rx_len   <= '0;
            r_rx_data  <= '0;
            r_rx_last  <= 1'b0;
        end else begin
            case (r_state)
                POLL_WAIT: begin
                    r_tx_cnt   <= '0;
                    r_tx_abort <= 1'b0;
                    r_tx_drop  <= 1'b0;
                    r_rx_idx   <= '0;
                    r_rx_len   <= '0;
                end
                TX_WR: begin
                    if (w_tx_hs) begin
                        r_tx_cnt <= r_tx_cnt + 9'd1;
                        if (w_tx_ovf) begin
                            r_tx_abort <= 1'b1;
                            r_tx_drop  <= 1'b1;
                        end
                        if (w_len_bad) begin
                            r_tx_abort <= 1'b1;
                        end
                    end
                end
                RX_WAIT: begin
                    r_rx_data <= bus.csr_readdata;
                    r_rx_last <= w_rx_last;
                    if (r_rx_idx == 9'd2) begin
                        r_rx_len <= bus.csr_readdata;
                    end
                end
                RX_OUT: begin
                    if (bus.rx_ready) begin
                        r_rx_idx <= r_rx_idx + 9'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.csr_address   = w_csr_address;
    assign bus.csr_read      = w_csr_read;
    assign bus.csr_write     = w_csr_write;
    assign bus.csr_writedata = w_csr_writedata;
    assign bus.tx_ready      = w_tx_ready;
    assign bus.tx_err        = w_tx_err;
    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = (r_state == RX_OUT);
    assign bus.rx_last       = (r_state == RX_OUT) && r_rx_last;
    assign bus.busy          = (r_state != IDLE);
endmodule

// File: tb/tb_cd_csr_host.sv
// tb_cd_csr_host: directed frames against a transaction-level model of expected CSR writes and RX bytes.
`timescale 1ns/1ps
module tb_cd_csr_host;
    localparam logic [4:0] A_FLAG = 5'h10;
    localparam logic [4:0] A_RXD  = 5'h14;
    localparam logic [4:0] A_TXD  = 5'h15;
    localparam logic [4:0] A_RXC  = 5'h16;
    localparam logic [4:0] A_TXC  = 5'h17;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cd_csr_host_if bus();

    cd_csr_host #(
        .ADDR_INT_FLAG(A_FLAG),
        .ADDR_RX_DATA (A_RXD),
        .ADDR_TX_DATA (A_TXD),
        .ADDR_RX_CTRL (A_RXC),
        .ADDR_TX_CTRL (A_TXC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    logic [7:0]  int_flag = 8'h00;
    logic [7:0]  rx_src[$];
    logic [7:0]  fq[$];
    logic [12:0] exp_wr[$];
    logic [8:0]  exp_rx[$];
    int exp_err;

    int n_txd, n_txc, first_txd, last_txd, n_flag_rd, n_tx_ready, n_stall, n_err, n_rx_last;
    logic [7:0] last_byte;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr();
        n_txd = 0; n_txc = 0; first_txd = 0; last_txd = 0; n_flag_rd = 0;
        n_tx_ready = 0; n_stall = 0; n_err = 0; n_rx_last = 0; exp_err = 0;
        last_byte = 8'h00;
    endtask

    task automatic load(input logic [63:0] v, input int n);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(v[8*(n-1-i) +: 8]);
    endtask

    // Model: every byte up to 256 is written to TX_DATA, then one TX_CTRL write decides the frame.
    task automatic model_tx(input logic [7:0] b[$]);
        int  n;
        logic bad;
        n = b.size();
        for (int i = 0; i < n && i < 256; i++) exp_wr.push_back({A_TXD, b[i]});
        if (n > 256) begin
            exp_wr.push_back({A_TXC, 8'h04});
            exp_err++;
        end else begin
            bad = 1'b0;
`ifdef CD_HOST_LEN_CHECK_EN
            bad = (n < 3) || (n != int'(b[2]) + 3);
`endif
            exp_wr.push_back({A_TXC, bad ? 8'h04 : 8'h02});
            if (bad) exp_err++;
        end
    endtask

    // Model: frame length is byte 2 plus three; the last byte carries rx_last; then RX_CTRL done.
    task automatic model_rx(input logic [7:0] b[$]);
        int n;
        n = int'(b[2]) + 3;
        for (int i = 0; i < n; i++) begin
            exp_rx.push_back({(i == n - 1), b[i]});
            rx_src.push_back(b[i]);
        end
        exp_wr.push_back({A_RXC, 8'h02});
    endtask

    task automatic send_tx(input logic [7:0] b[$], input int stop_after);
        int   i;
        int   g;
        int   target;
        logic hs;
        i = 0; g = 0;
        target = (stop_after >= 0) ? stop_after : b.size();
        @(posedge clk); #1;
        bus.tx_valid = 1'b1; bus.tx_data = b[0]; bus.tx_last = (b.size() == 1);
        while (i < target && g < 2000) begin
            @(negedge clk); hs = bus.tx_ready;
            @(posedge clk); #1; g++;
            if (hs) begin
                i++;
                if (i < b.size()) begin
                    bus.tx_data = b[i];
                    bus.tx_last = (i == b.size() - 1);
                end
            end
        end
        bus.tx_valid = 1'b0; bus.tx_last = 1'b0;
        chk("tx_bytes_accepted", 32'(i), 32'(target));
    endtask

    task automatic recv_rx(input int n, input int stall_at, input int stall_len);
        int g;
        for (int k = 0; k < n; k++) begin
            g = 0;
            @(posedge clk); #1;
            while (!bus.rx_valid && g < 200) begin @(posedge clk); #1; g++; end
            chk("rx_byte_arrives", 32'(bus.rx_valid), 32'd1);
            if (k == stall_at) repeat (stall_len) begin @(posedge clk); #1; end
            bus.rx_ready = 1'b1;
            @(posedge clk); #1;
            bus.rx_ready = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int g;
        g = 0;
        while ((exp_wr.size() != 0 || exp_rx.size() != 0 || bus.busy) && g < 3000) begin
            @(negedge clk); g++;
        end
        chk({name, "_completes"}, 32'(g < 3000), 32'd1);
        repeat (6) @(negedge clk);
        chk({name, "_tx_err_pulses"}, 32'(n_err), 32'(exp_err));
    endtask

    task automatic check_reset_vals(input string t);
        chk({t, "_csr_read"},      32'(bus.csr_read),      32'd0);
        chk({t, "_csr_write"},     32'(bus.csr_write),     32'd0);
        chk({t, "_csr_address"},   32'(bus.csr_address),   32'd0);
        chk({t, "_csr_writedata"}, 32'(bus.csr_writedata), 32'd0);
        chk({t, "_tx_ready"},      32'(bus.tx_ready),      32'd0);
        chk({t, "_rx_valid"},      32'(bus.rx_valid),      32'd0);
        chk({t, "_rx_last"},       32'(bus.rx_last),       32'd0);
        chk({t, "_rx_data"},       32'(bus.rx_data),       32'd0);
        chk({t, "_tx_err"},        32'(bus.tx_err),        32'd0);
        chk({t, "_busy"},          32'(bus.busy),          32'd0);
    endtask

    // Controller register file: read data appears the cycle after the strobe.
    always @(negedge clk) begin
        if (bus.csr_read) begin
            if (bus.csr_address == A_FLAG) bus.csr_readdata = int_flag;
            else if (bus.csr_address == A_RXD) bus.csr_readdata = (rx_src.size() != 0) ? rx_src.pop_front() : 8'hEE;
        end
        if (bus.csr_write && bus.csr_address == A_RXC && bus.csr_writedata == 8'h02) begin
            int_flag[1] = 1'b0;
            bus.irq = 1'b0;
        end
    end

    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       p_err   = 1'b0;
    logic [7:0] p_data  = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chk("strobe_exclusive", 32'(bus.csr_read & bus.csr_write), 32'd0);
            chk("no_read_while_rx_valid", 32'(bus.csr_read & bus.rx_valid), 32'd0);
            chk("tx_err_single_cycle", 32'(p_err & bus.tx_err), 32'd0);
            if (p_valid && !p_ready) begin
                chk("rx_valid_held", 32'(bus.rx_valid), 32'd1);
                chk("rx_data_stable", 32'(bus.rx_data), 32'(p_data));
            end
            if (bus.csr_read) begin
                chk("read_address", 32'(bus.csr_address == A_FLAG || bus.csr_address == A_RXD), 32'd1);
                if (bus.csr_address == A_FLAG) n_flag_rd++;
            end
            if (bus.csr_write) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL csr_write_unexpected: got addr %0h data %0h expected none (cycle %0d)",
                             bus.csr_address, bus.csr_writedata, cyc);
                end else begin
                    chk("csr_write", 32'({bus.csr_address, bus.csr_writedata}), 32'(exp_wr.pop_front()));
                end
                if (bus.csr_address == A_TXD) begin
                    if (n_txd == 0) first_txd = int'(cyc);
                    last_txd = int'(cyc);
                    n_txd++;
                end
                if (bus.csr_address == A_TXC) n_txc++;
            end
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_rx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_byte_unexpected: got %0h expected none (cycle %0d)", bus.rx_data, cyc);
                end else begin
                    chk("rx_byte", 32'({bus.rx_last, bus.rx_data}), 32'(exp_rx.pop_front()));
                end
                if (bus.rx_last) begin
                    n_rx_last++;
                    last_byte = bus.rx_data;
                end
            end
            if (bus.tx_ready) n_tx_ready++;
            if (bus.tx_err) n_err++;
            if (bus.rx_valid && !bus.rx_ready) n_stall++;
        end
        p_valid = bus.rx_valid;
        p_ready = bus.rx_ready;
        p_err   = bus.tx_err;
        p_data  = bus.rx_data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.irq = 1'b0; bus.csr_readdata = 8'h00; bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0; bus.tx_last = 1'b0; bus.rx_ready = 1'b0;
        clr();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1 reset = 1'b0;

        // RX frame 01 02 02 AA BB with consumer always ready
        clr(); int_flag = 8'h02; load(64'h01_02_02_AA_BB, 5); model_rx(fq);
        @(posedge clk); #1; bus.rx_ready = 1'b1; bus.irq = 1'b1;
        wait_done("rx_basic");
        chk("rx_basic_last_byte", 32'(last_byte), 32'h0000_00BB);
        chk("rx_basic_last_count", 32'(n_rx_last), 32'd1);
        bus.rx_ready = 1'b0;

        // TX frame 01 02 01 55 with clean TX buffer
        clr(); int_flag = 8'h20; load(64'h01_02_01_55, 4); model_tx(fq);
        send_tx(fq, -1);
        wait_done("tx_basic");
        chk("tx_basic_data_writes", 32'(n_txd), 32'd4);
        chk("tx_basic_back_to_back", 32'(last_txd - first_txd), 32'd3);
        chk("tx_basic_ctrl_writes", 32'(n_txc), 32'd1);

        // TX pending but buffer not clean: polls repeat, nothing accepted
        clr(); int_flag = 8'h00;
        @(posedge clk); #1; bus.tx_valid = 1'b1; bus.tx_data = 8'h33;
        repeat (20) @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        wait_done("tx_unclean");
        chk("tx_unclean_tx_ready", 32'(n_tx_ready), 32'd0);
        chk("tx_unclean_data_writes", 32'(n_txd), 32'd0);
        chk("tx_unclean_repolls", 32'(n_flag_rd >= 3), 32'd1);

        // RX frame 03 04 01 CC, consumer stalls 10 cycles on byte index 3
        clr(); int_flag = 8'h02; load(64'h03_04_01_CC, 4); model_rx(fq);
        @(posedge clk); #1; bus.irq = 1'b1;
        recv_rx(4, 3, 10);
        wait_done("rx_stall");
        chk("rx_stall_cycles", 32'(n_stall), 32'd10);
        chk("rx_stall_last_byte", 32'(last_byte), 32'h0000_00CC);

        // RX zero-length payload: three bytes, last on the length byte
        clr(); int_flag = 8'h02; load(64'h05_06_00, 3); model_rx(fq);
        @(posedge clk); #1; bus.rx_ready = 1'b1; bus.irq = 1'b1;
        wait_done("rx_len0");
        chk("rx_len0_last_byte", 32'(last_byte), 32'd0);
        chk("rx_len0_last_count", 32'(n_rx_last), 32'd1);
        bus.rx_ready = 1'b0;

        // TX overflow: 258 bytes, last on the 258th
        clr(); int_flag = 8'h20;
        fq.delete();
        for (int i = 0; i < 258; i++) fq.push_back(8'(i));
        model_tx(fq);
        send_tx(fq, -1);
        wait_done("tx_overflow");
        chk("tx_overflow_data_writes", 32'(n_txd), 32'd256);
        chk("tx_overflow_err_pulses", 32'(n_err), 32'd1);
        chk("tx_overflow_ready_cycles", 32'(n_tx_ready), 32'd258);

        // TX frame whose length byte disagrees with its size
        clr(); int_flag = 8'h20; load(64'h01_02_05_55, 4); model_tx(fq);
        send_tx(fq, -1);
        wait_done("tx_lenmis");
`ifdef CD_HOST_LEN_CHECK_EN
        chk("tx_lenmis_err_pulses", 32'(n_err), 32'd1);
`else
        chk("tx_lenmis_err_pulses", 32'(n_err), 32'd0);
`endif

        // Reset after two accepted TX bytes abandons the frame
        clr(); int_flag = 8'h20; load(64'h01_02_01_55, 4);
        exp_wr.push_back({A_TXD, 8'h01});
        exp_wr.push_back({A_TXD, 8'h02});
        send_tx(fq, 2);
        reset = 1'b1;
        #1 check_reset_vals("reset_async");
        @(negedge clk);
        check_reset_vals("reset_midframe");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_midframe_pending_writes", 32'(exp_wr.size()), 32'd0);
        chk("reset_midframe_ctrl_writes", 32'(n_txc), 32'd0);
        chk("reset_midframe_data_writes", 32'(n_txd), 32'd2);

        // Recovery: a normal frame after the abandoned one
        clr(); int_flag = 8'h20; load(64'h01_02_01_55, 4); model_tx(fq);
        send_tx(fq, -1);
        wait_done("tx_recover");
        chk("tx_recover_data_writes", 32'(n_txd), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
